// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin arbiter sharing one multiplier between requesters
module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64,
    parameter int MUL_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b_i,
    output logic [NUM_REQ-1:0]         rsp_valid_o,
    input  logic [NUM_REQ-1:0]         rsp_ready_i,
    output logic [WIDTH-1:0]           rsp_result_o,
    output logic [WIDTH-1:0]           mul_a_o,
    output logic [WIDTH-1:0]           mul_b_o,
    input  logic [WIDTH-1:0]           mul_result_i,
    output logic                       busy_o,
    output logic [CNT_W-1:0]           op_count_o
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [LW-1:0] LAT_INIT = LW'(MUL_LAT - 1);
    localparam logic [GW-1:0] LAST_REQ = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e               state_q;
    logic [GW-1:0]        rr_ptr_q;
    logic [GW-1:0]        rr_ptr_d;
    logic [GW-1:0]        grant_q;
    logic [GW-1:0]        win_d;
    logic                 win_found_d;
    logic [LW-1:0]        cnt_q;
    logic [WIDTH-1:0]     mul_a_q;
    logic [WIDTH-1:0]     mul_b_q;
    logic [WIDTH-1:0]     rsp_result_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic                 busy_q;
    logic [CNT_W-1:0]     op_count_q;
    logic [CNT_W-1:0]     op_count_d;

    // Requester index base+off folded back into 0..NUM_REQ-1 (off < NUM_REQ).
    function automatic logic [GW-1:0] wrap_idx(input int s);
        return (s >= NUM_REQ) ? GW'(s - NUM_REQ) : GW'(s);
    endfunction

    // Round-robin search: first valid requester at or after rr_ptr.
    always_comb begin
        win_found_d = 1'b0;
        win_d       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found_d && req_valid_i[wrap_idx(int'(rr_ptr_q) + k)]) begin
                win_found_d = 1'b1;
                win_d       = wrap_idx(int'(rr_ptr_q) + k);
            end
        end
    end

    // Accept strobe is only offered while idle and out of reset.
    always_comb begin
        req_ready_o = '0;
        if (rst_ni && (state_q == ST_IDLE) && win_found_d) begin
            req_ready_o[win_d] = 1'b1;
        end
    end

    // Pointer after the current grant and the saturating completion count.
    always_comb begin
        rr_ptr_d   = (grant_q == LAST_REQ) ? '0 : grant_q + GW'(1);
        op_count_d = (&op_count_q) ? op_count_q : op_count_q + CNT_W'(1);
    end

    // Main FSM: accept, wait out multiplier latency, hold the response until taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            cnt_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            rsp_result_q <= '0;
            rsp_valid_q  <= '0;
            busy_q       <= 1'b0;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_found_d) begin
                        mul_a_q <= req_a_i[win_d*WIDTH +: WIDTH];
                        mul_b_q <= req_b_i[win_d*WIDTH +: WIDTH];
                        grant_q <= win_d;
                        cnt_q   <= LAT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - LW'(1);
                    end else begin
                        rsp_result_q <= mul_result_i;
                        rsp_valid_q  <= NUM_REQ'(1) << grant_q;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i[grant_q]) begin
                        rsp_valid_q <= '0;
                        busy_q      <= 1'b0;
                        rr_ptr_q    <= rr_ptr_d;
                        op_count_q  <= op_count_d;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= '0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign mul_a_o      = mul_a_q;
    assign mul_b_o      = mul_b_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign busy_o       = busy_q;
    assign op_count_o   = op_count_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - self-checking bench for mult_share_arbiter
module tb_mult_share_arbiter;

    localparam int N = 4;
    localparam int W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // MUL_LAT=1 instance with a combinational multiplier
    logic [N-1:0]   req_valid, rsp_ready, req_ready, rsp_valid;
    logic [N*W-1:0] req_a, req_b;
    logic [W-1:0]   rsp_result, mul_a, mul_b, mul_result;
    logic           busy;
    logic [31:0]    op_count;
    assign mul_result = mul_a * mul_b;

    // MUL_LAT=3 instance, 2-bit counter, multiplier delayed by two register stages
    logic [N-1:0]   req_valid3, rsp_ready3, req_ready3, rsp_valid3;
    logic [N*W-1:0] req_a3, req_b3;
    logic [W-1:0]   rsp_result3, mul_a3, mul_b3, mul_result3, pipe1, pipe2;
    logic           busy3;
    logic [1:0]     op_count3;
    always @(posedge clk) begin
        pipe1 <= mul_a3 * mul_b3;
        pipe2 <= pipe1;
    end
    assign mul_result3 = pipe2;

    mult_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .MUL_LAT(1), .CNT_W(32)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
        .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_result_i(mul_result),
        .busy_o(busy), .op_count_o(op_count)
    );

    mult_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .MUL_LAT(3), .CNT_W(2)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid3), .req_ready_o(req_ready3),
        .req_a_i(req_a3), .req_b_i(req_b3),
        .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3), .rsp_result_o(rsp_result3),
        .mul_a_o(mul_a3), .mul_b_o(mul_b3), .mul_result_i(mul_result3),
        .busy_o(busy3), .op_count_o(op_count3)
    );

    int n_tests = 0;
    int n_fail  = 0;
    // Reference model state: next search start and completed ops
    int m_rr  = 0;
    int m_cnt = 0;

    function automatic int winner(input logic [N-1:0] v, input int rr);
        for (int k = 0; k < N; k++) begin
            if (v[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] r;
        r = '0;
        if (i >= 0 && i < N) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        return a * b;
    endfunction

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Raise one request and wait until it is accepted; drops valid afterwards.
    task automatic issue(input int idx, input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        req_valid[idx] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[idx]) ok = 1'b1;
            @(posedge clk); #1;
        end
        req_valid[idx] = 1'b0;
    endtask

    // Wait for a response on the MUL_LAT=1 instance; handshake happens when rsp_ready is set.
    task automatic wait_rsp(output logic [N-1:0] v, output logic [W-1:0] r);
        v = '0;
        r = '0;
        for (int c = 0; c < 20 && v == '0; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                v = rsp_valid;
                r = rsp_result;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '1; rsp_ready = '0; req_a = '0; req_b = '0;
        req_valid3 = '0; rsp_ready3 = '0; req_a3 = '0; req_b3 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (req_ready !== '0 || rsp_valid !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: req_ready=%b rsp_valid=%b busy=%b, want all 0", req_ready, rsp_valid, busy);
        end
        n_tests++;
        if (rsp_result !== '0 || mul_a !== '0 || mul_b !== '0 || op_count !== '0) begin
            n_fail++;
            $display("FAIL reset_data: rsp_result=%h mul_a=%h mul_b=%h op_count=%0d, want 0", rsp_result, mul_a, mul_b, op_count);
        end
        n_tests++;
        if (req_ready3 !== '0 || rsp_valid3 !== '0 || busy3 !== 1'b0 || op_count3 !== '0) begin
            n_fail++;
            $display("FAIL reset_lat3: req_ready=%b rsp_valid=%b busy=%b op_count=%0d, want 0", req_ready3, rsp_valid3, busy3, op_count3);
        end
        req_valid = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        m_rr = 0; m_cnt = 0;
    endtask

    task automatic test_single_op();
        req_a[0 +: W] = 64'd3;
        req_b[0 +: W] = 64'd5;
        req_valid = 4'b0001;
        rsp_ready = 4'b0001;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_accept: req_ready=%b, want 0001", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        req_a[0 +: W] = 64'd77;
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== '0 || mul_a !== 64'd3 || mul_b !== 64'd5 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_exec: rsp_valid=%b mul_a=%0d mul_b=%0d busy=%b, want 0000 3 5 1", rsp_valid, mul_a, mul_b, busy);
        end
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 4'b0001 || rsp_result !== 64'd15) begin
            n_fail++;
            $display("FAIL single_rsp: rsp_valid=%b rsp_result=%0d, want 0001 15", rsp_valid, rsp_result);
        end
        @(posedge clk); #1;
        m_cnt++; m_rr = 1;
        @(negedge clk);
        n_tests++;
        if (op_count !== 32'(m_cnt) || rsp_valid !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: op_count=%0d rsp_valid=%b busy=%b, want %0d 0000 0", op_count, rsp_valid, busy, m_cnt);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (mul_a !== 64'd3 || mul_b !== 64'd5) begin
            n_fail++;
            $display("FAIL idle_hold: mul_a=%0d mul_b=%0d, want 3 5", mul_a, mul_b);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        bit ok;
        logic [N-1:0] v;
        logic [W-1:0] r;
        rsp_ready = '1;
        issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, ok);
        wait_rsp(v, r);
        n_tests++;
        if (!ok || v !== 4'b0010 || r !== 64'h1) begin
            n_fail++;
            $display("FAIL wrap_ones: accepted=%0d rsp_valid=%b result=%h, want 1 0010 1", ok, v, r);
        end
        m_cnt++; m_rr = 2;
        issue(2, 64'h1_0000_0000, 64'h1_0000_0000, ok);
        wait_rsp(v, r);
        n_tests++;
        if (!ok || v !== 4'b0100 || r !== 64'h0) begin
            n_fail++;
            $display("FAIL wrap_2p64: accepted=%0d rsp_valid=%b result=%h, want 1 0100 0", ok, v, r);
        end
        m_cnt++; m_rr = 3;
    endtask

    // Streams ops through the MUL_LAT=1 instance checking grants and products against the model.
    task automatic run_traffic(input int n_ops, input bit rnd_valid, input bit rnd_ready);
        int done, pend, multi, ex, acc;
        logic [W-1:0] pprod;
        done = 0; pend = -1; multi = 0; pprod = '0;
        for (int c = 0; c < 3000 && done < n_ops; c++) begin
            acc = -1;
            @(negedge clk);
            if ($countones(req_ready) > 1 || $countones(rsp_valid) > 1) multi++;
            if (req_ready != '0) begin
                ex = winner(req_valid, m_rr);
                n_tests++;
                if (req_ready !== onehot(ex)) begin
                    n_fail++;
                    $display("FAIL traffic_grant: req_ready=%b, want %b", req_ready, onehot(ex));
                end
                if (ex >= 0) begin
                    acc = ex; pend = ex;
                    pprod = prod(req_a[ex*W +: W], req_b[ex*W +: W]);
                end
            end
            if (rsp_valid != '0) begin
                n_tests++;
                if (rsp_valid !== onehot(pend) || rsp_result !== pprod) begin
                    n_fail++;
                    $display("FAIL traffic_rsp: rsp_valid=%b result=%h, want %b %h", rsp_valid, rsp_result, onehot(pend), pprod);
                end
                if (pend >= 0 && rsp_ready[pend]) begin
                    m_rr = (pend + 1) % N;
                    m_cnt++;
                    done++;
                end
            end
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (!rnd_valid) begin
                    if (i == acc) begin
                        req_a[i*W +: W] = rnd64();
                        req_b[i*W +: W] = rnd64();
                    end
                    req_valid[i] = 1'b1;
                end else if (i == acc || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(2) == 0);
                    req_a[i*W +: W] = rnd64();
                    req_b[i*W +: W] = ($urandom_range(5) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : rnd64();
                end else if ($urandom_range(7) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = rnd_ready ? N'($urandom) : '1;
        end
        req_valid = '0;
        rsp_ready = '1;
        n_tests++;
        if (done != n_ops) begin
            n_fail++;
            $display("FAIL traffic_timeout: completed=%0d, want %0d", done, n_ops);
        end
        n_tests++;
        if (multi != 0) begin
            n_fail++;
            $display("FAIL traffic_onehot: multi-bit cycles=%0d, want 0", multi);
        end
        n_tests++;
        if (op_count !== 32'(m_cnt)) begin
            n_fail++;
            $display("FAIL traffic_count: op_count=%0d, want %0d", op_count, m_cnt);
        end
    endtask

    task automatic test_all_valid();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = rnd64();
            req_b[i*W +: W] = rnd64();
        end
        req_valid = '1;
        rsp_ready = '1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_rr = 0; m_cnt = 0;
        run_traffic(9, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        run_traffic(40, 1'b1, 1'b1);
    endtask

    task automatic test_backpressure();
        bit ok, got;
        logic [W-1:0] p1, p2, r;
        logic [N-1:0] v;
        int ex;
        rsp_ready = 4'b1101;
        p1 = rnd64();
        p2 = rnd64();
        issue(1, p1, p2, ok);
        p1 = prod(p1, p2);
        for (int i = 0; i < N; i++) begin
            if (i != 1) begin
                req_a[i*W +: W] = rnd64();
                req_b[i*W +: W] = rnd64();
                req_valid[i] = 1'b1;
            end
        end
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            got = (rsp_valid != '0);
            @(posedge clk); #1;
        end
        n_tests++;
        if (!ok || !got) begin
            n_fail++;
            $display("FAIL bp_start: accepted=%0d rsp_seen=%0d, want 1 1", ok, got);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_tests++;
            if (rsp_valid !== 4'b0010 || rsp_result !== p1 || req_ready !== '0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_stall: rsp_valid=%b result=%h req_ready=%b busy=%b, want 0010 %h 0000 1",
                         rsp_valid, rsp_result, req_ready, busy, p1);
            end
            @(posedge clk); #1;
        end
        rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        m_cnt++; m_rr = 2;
        @(negedge clk);
        ex = winner(4'b1101, m_rr);
        p2 = prod(req_a[ex*W +: W], req_b[ex*W +: W]);
        n_tests++;
        if (req_ready !== onehot(ex)) begin
            n_fail++;
            $display("FAIL bp_next_grant: req_ready=%b, want %b", req_ready, onehot(ex));
        end
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = '1;
        wait_rsp(v, r);
        n_tests++;
        if (v !== onehot(ex) || r !== p2) begin
            n_fail++;
            $display("FAIL bp_next_rsp: rsp_valid=%b result=%h, want %b %h", v, r, onehot(ex), p2);
        end
        m_cnt++; m_rr = (ex + 1) % N;
        n_tests++;
        if (op_count !== 32'(m_cnt)) begin
            n_fail++;
            $display("FAIL bp_count: op_count=%0d, want %0d", op_count, m_cnt);
        end
    endtask

    task automatic test_mul_lat3();
        logic [W-1:0] a, b, r;
        logic [N-1:0] v;
        int lat, cnt3;
        cnt3 = 0;
        rsp_ready3 = '1;
        for (int k = 0; k < 4; k++) begin
            a = rnd64(); b = rnd64();
            req_a3[k*W +: W] = a;
            req_b3[k*W +: W] = b;
            req_valid3 = onehot(k);
            @(negedge clk);
            n_tests++;
            if (req_ready3 !== onehot(k)) begin
                n_fail++;
                $display("FAIL lat3_accept: req_ready=%b, want %b", req_ready3, onehot(k));
            end
            @(posedge clk); #1;
            req_valid3 = '0;
            lat = -1; r = '0; v = '0;
            for (int c = 1; c <= 8 && lat < 0; c++) begin
                @(negedge clk);
                if (rsp_valid3 != '0) begin
                    lat = c; r = rsp_result3; v = rsp_valid3;
                end
                @(posedge clk); #1;
            end
            cnt3 = (cnt3 < 3) ? cnt3 + 1 : 3;
            n_tests++;
            if (lat != 4 || v !== onehot(k) || r !== prod(a, b)) begin
                n_fail++;
                $display("FAIL lat3_rsp: latency=%0d rsp_valid=%b result=%h, want 4 %b %h", lat, v, r, onehot(k), prod(a, b));
            end
            n_tests++;
            if (op_count3 !== 2'(cnt3)) begin
                n_fail++;
                $display("FAIL lat3_count_sat: op_count=%0d, want %0d", op_count3, cnt3);
            end
        end
    endtask

    task automatic test_reset_exec();
        int quiet;
        logic [N-1:0] v;
        logic [W-1:0] r, p;
        rsp_ready = '1;
        req_a[2*W +: W] = rnd64() | 64'h1;
        req_b[2*W +: W] = rnd64() | 64'h1;
        req_valid = 4'b0100;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL rexec_accept: req_ready=%b, want 0100", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rexec_busy: busy=%b, want 1", busy);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (req_ready !== '0 || rsp_valid !== '0 || rsp_result !== '0 || mul_a !== '0 ||
            mul_b !== '0 || busy !== 1'b0 || op_count !== '0) begin
            n_fail++;
            $display("FAIL rexec_async: req_ready=%b rsp_valid=%b result=%h mul_a=%h mul_b=%h busy=%b op_count=%0d, want all 0",
                     req_ready, rsp_valid, rsp_result, mul_a, mul_b, busy, op_count);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_rr = 0; m_cnt = 0;
        quiet = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rsp_valid != '0 || busy != 1'b0) quiet++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (quiet != 0) begin
            n_fail++;
            $display("FAIL rexec_dropped: active cycles after reset=%0d, want 0", quiet);
        end
        req_a[3*W +: W] = rnd64();
        req_b[3*W +: W] = rnd64();
        req_valid = 4'b1100;
        p = prod(req_a[2*W +: W], req_b[2*W +: W]);
        @(negedge clk);
        n_tests++;
        if (req_ready !== onehot(winner(4'b1100, m_rr))) begin
            n_fail++;
            $display("FAIL rexec_rr_ptr: req_ready=%b, want %b", req_ready, onehot(winner(4'b1100, m_rr)));
        end
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(v, r);
        m_cnt++;
        n_tests++;
        if (v !== 4'b0100 || r !== p || op_count !== 32'(m_cnt)) begin
            n_fail++;
            $display("FAIL rexec_fresh_op: rsp_valid=%b result=%h op_count=%0d, want 0100 %h %0d", v, r, op_count, p, m_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_wrap();
        test_all_valid();
        test_random();
        test_backpressure();
        test_mul_lat3();
        test_reset_exec();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
